// File: rtl/timer_pkg.sv
// Shared definitions for the bcd_timer block.
//   bcd_t          : one 4-bit BCD digit
//   DIR_UP/DOWN    : encodings of the DIR input
//   seg7()         : hex digit -> active-low 7-segment pattern {g,f,e,d,c,b,a}
//   limit_bcd()    : two-digit BCD form of a minutes limit (0..99)
//   sanitise()     : clamp a {m_hi,m_lo,s_hi,s_lo} BCD word into the legal range
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] limit_bcd(input int unsigned lim);
    logic [7:0] r;
    r = {4'(lim / 32'd10), 4'(lim % 32'd10)};
    return r;
  endfunction

  // Digit-wise clamp first, then compare the whole minutes value to the
  // limit so that e.g. m_hi=7 with a limit of 59 collapses to 59.
  function automatic logic [15:0] sanitise(input logic [15:0] v,
                                           input int unsigned min_limit);
    bcd_t        m_hi;
    bcd_t        m_lo;
    bcd_t        s_hi;
    bcd_t        s_lo;
    int unsigned minutes;
    logic [7:0]  lim;
    s_lo = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
    s_hi = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
    m_lo = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
    m_hi = v[15:12];
    minutes = 32'(m_hi) * 32'd10 + 32'(m_lo);
    if (minutes > min_limit) begin
      lim  = limit_bcd(min_limit);
      m_hi = lim[7:4];
      m_lo = lim[3:0];
    end
    return {m_hi, m_lo, s_hi, s_lo};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counter, 0..MAX.
//   clk, rst : clock, asynchronous active-high reset (digit -> 0)
//   inc, dec : advance up / down by one (inc wins if both set)
//   load     : take value (overrides inc/dec)
//   value    : digit to load
//   q        : current digit
//   carry    : inc while at MAX (this digit rolls to 0)
//   borrow   : dec while at 0 (this digit rolls to MAX)
module bcd_digit
  import timer_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t value,
  output bcd_t q,
  output logic carry,
  output logic borrow
);

  localparam bcd_t MAX_V = 4'(MAX);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = value;
    end else if (inc) begin
      q_d = (q_q >= MAX_V) ? '0 : q_q + 4'd1;
    end else if (dec) begin
      q_d = (q_q == '0) ? MAX_V : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign carry  = inc && !load && (q_q >= MAX_V);
  assign borrow = dec && !inc && !load && (q_q == '0);

endmodule

// File: rtl/bcd_timer.sv
// mm:ss up/down timer with BCD state and four 7-segment outputs.
//   CLK, RST    : clock, asynchronous active-high reset
//   RUN         : prescaler and counter advance
//   DIR         : 0 count up, 1 count down
//   FAST        : use the shortened tick period
//   LOAD        : load sanitised LOAD_VALUE (beats any step)
//   LOAD_VALUE  : BCD {m_hi,m_lo,s_hi,s_lo}
//   FREEZE      : hold the display latch; counting continues
//   DIGITS      : live BCD count
//   HEX0..HEX3  : active-low segments of the latched s_lo,s_hi,m_lo,m_hi
//   TICK        : one-cycle pulse on each count step
//   DONE        : one-cycle pulse on each terminal event
module bcd_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned FAST_FACTOR = 10,
  parameter int unsigned MIN_LIMIT   = 59,
  parameter bit          WRAP        = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic        DIR,
  input  logic        FAST,
  input  logic        LOAD,
  input  logic [15:0] LOAD_VALUE,
  input  logic        FREEZE,
  output logic [15:0] DIGITS,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        TICK,
  output logic        DONE
);

  localparam int unsigned PW          = $clog2(TICK_DIV);
  localparam int unsigned FAST_DIV    = (FAST_FACTOR == 0) ? TICK_DIV : TICK_DIV / FAST_FACTOR;
  localparam int unsigned FAST_PERIOD = (FAST_DIV < 1) ? 1 : FAST_DIV;
  localparam logic [PW-1:0] SLOW_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_PERIOD - 1);
  localparam logic [7:0]    LIMIT_BCD = limit_bcd(MIN_LIMIT);

  // Registered state
  logic [PW-1:0] presc_q, presc_d;
  logic          stopped_q, stopped_d;
  logic          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic [15:0]   disp_q, disp_d;

  // Digit interface
  bcd_t s_lo, s_hi, m_lo, m_hi;
  logic s_lo_inc, s_lo_dec, s_lo_carry, s_lo_borrow;
  logic s_hi_carry, s_hi_borrow;
  logic m_lo_carry, m_lo_borrow;
  logic m_hi_carry, m_hi_borrow;
  logic        ld_all;
  logic [15:0] ld_value;

  // Step control
  logic          stopped_eff;
  logic          active;
  logic [PW-1:0] period_last;
  logic          step;
  logic          go;
  logic          down;
  logic          at_end;
  logic          term;

  // A DIR change releases a stopped timer in the same cycle, so the
  // prescaler resumes immediately rather than one cycle later.
  always_comb begin
    stopped_eff = stopped_q && (DIR == dir_q);
    active      = RUN && !stopped_eff;
    period_last = FAST ? FAST_LAST : SLOW_LAST;
    // >= rather than == so a switch to the shorter period mid-count fires at once.
    step        = active && (presc_q >= period_last);
    go          = step && !LOAD;
    down        = (DIR == DIR_DOWN);
    if (down) begin
      at_end = ({m_hi, m_lo} == 8'h00) && ({s_hi, s_lo} == 8'h00);
    end else begin
      at_end = ({m_hi, m_lo} == LIMIT_BCD) && ({s_hi, s_lo} == 8'h59);
    end
    term = go && at_end;
  end

  // Terminal steps never ripple through the digit chain: they either reload
  // the whole count (wrap) or leave it untouched (saturate).
  always_comb begin
    s_lo_inc = go && !down && !term;
    s_lo_dec = go &&  down && !term;
    ld_all   = LOAD || (term && WRAP);
    if (LOAD) begin
      ld_value = sanitise(LOAD_VALUE, MIN_LIMIT);
    end else if (down) begin
      ld_value = {LIMIT_BCD, 8'h59};
    end else begin
      ld_value = 16'h0000;
    end
  end

  bcd_digit #(.MAX(9)) u_s_lo (
    .clk    (CLK),
    .rst    (RST),
    .inc    (s_lo_inc),
    .dec    (s_lo_dec),
    .load   (ld_all),
    .value  (ld_value[3:0]),
    .q      (s_lo),
    .carry  (s_lo_carry),
    .borrow (s_lo_borrow)
  );

  bcd_digit #(.MAX(5)) u_s_hi (
    .clk    (CLK),
    .rst    (RST),
    .inc    (s_lo_carry),
    .dec    (s_lo_borrow),
    .load   (ld_all),
    .value  (ld_value[7:4]),
    .q      (s_hi),
    .carry  (s_hi_carry),
    .borrow (s_hi_borrow)
  );

  // Minutes never exceed MIN_LIMIT outside a terminal step, so plain 0..9
  // digits suffice; the limit itself is enforced by at_end and the reload.
  bcd_digit #(.MAX(9)) u_m_lo (
    .clk    (CLK),
    .rst    (RST),
    .inc    (s_hi_carry),
    .dec    (s_hi_borrow),
    .load   (ld_all),
    .value  (ld_value[11:8]),
    .q      (m_lo),
    .carry  (m_lo_carry),
    .borrow (m_lo_borrow)
  );

  bcd_digit #(.MAX(9)) u_m_hi (
    .clk    (CLK),
    .rst    (RST),
    .inc    (m_lo_carry),
    .dec    (m_lo_borrow),
    .load   (ld_all),
    .value  (ld_value[15:12]),
    .q      (m_hi),
    .carry  (m_hi_carry),
    .borrow (m_hi_borrow)
  );

  // The top digit's carry/borrow cannot occur: terminal detection catches it first.
  logic unused_top_digit;
  assign unused_top_digit = m_hi_carry | m_hi_borrow;

  always_comb begin
    presc_d = presc_q;
    if (LOAD || step) begin
      presc_d = '0;
    end else if (active) begin
      presc_d = presc_q + PW'(1);
    end
    stopped_d = !LOAD && (stopped_eff || (term && !WRAP));
    dir_d     = DIR;
    tick_d    = go;
    done_d    = term;
    disp_d    = FREEZE ? disp_q : DIGITS;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q   <= '0;
      stopped_q <= 1'b0;
      dir_q     <= DIR_UP;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      disp_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      stopped_q <= stopped_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      disp_q    <= disp_d;
    end
  end

  always_comb begin
    DIGITS = {m_hi, m_lo, s_hi, s_lo};
    TICK   = tick_q;
    DONE   = done_q;
    HEX0   = seg7(disp_q[3:0]);
    HEX1   = seg7(disp_q[7:4]);
    HEX2   = seg7(disp_q[11:8]);
    HEX3   = seg7(disp_q[15:12]);
  end

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer: three instances share the inputs
// (wrap/limit 59, saturate/limit 59, wrap/limit 12).
module tb_bcd_timer;

  logic        clk = 1'b0;
  logic        rst, run, dir, fast, load, freeze;
  logic [15:0] load_value;

  logic [15:0] w_digits, s_digits, l_digits;
  logic [6:0]  w_hex0, w_hex1, w_hex2, w_hex3;
  logic [6:0]  s_hex0, s_hex1, s_hex2, s_hex3;
  logic [6:0]  l_hex0, l_hex1, l_hex2, l_hex3;
  logic        w_tick, w_done, s_tick, s_done, l_tick, l_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_timer #(.TICK_DIV(4), .FAST_FACTOR(2), .MIN_LIMIT(59), .WRAP(1'b1)) u_wrap (
    .CLK(clk), .RST(rst), .RUN(run), .DIR(dir), .FAST(fast), .LOAD(load),
    .LOAD_VALUE(load_value), .FREEZE(freeze), .DIGITS(w_digits),
    .HEX0(w_hex0), .HEX1(w_hex1), .HEX2(w_hex2), .HEX3(w_hex3),
    .TICK(w_tick), .DONE(w_done)
  );

  bcd_timer #(.TICK_DIV(4), .FAST_FACTOR(2), .MIN_LIMIT(59), .WRAP(1'b0)) u_sat (
    .CLK(clk), .RST(rst), .RUN(run), .DIR(dir), .FAST(fast), .LOAD(load),
    .LOAD_VALUE(load_value), .FREEZE(freeze), .DIGITS(s_digits),
    .HEX0(s_hex0), .HEX1(s_hex1), .HEX2(s_hex2), .HEX3(s_hex3),
    .TICK(s_tick), .DONE(s_done)
  );

  bcd_timer #(.TICK_DIV(4), .FAST_FACTOR(2), .MIN_LIMIT(12), .WRAP(1'b1)) u_lim (
    .CLK(clk), .RST(rst), .RUN(run), .DIR(dir), .FAST(fast), .LOAD(load),
    .LOAD_VALUE(load_value), .FREEZE(freeze), .DIGITS(l_digits),
    .HEX0(l_hex0), .HEX1(l_hex1), .HEX2(l_hex2), .HEX3(l_hex3),
    .TICK(l_tick), .DONE(l_done)
  );

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    clk_n(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clk_n(2);
    n_cmp++; if (w_digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits got=%h exp=0000", w_digits); end
    n_cmp++; if ({w_hex3, w_hex2, w_hex1, w_hex0} !== {4{7'b1000000}}) begin
      n_bad++; $display("FAIL reset_hex got=%h exp=%h", {w_hex3, w_hex2, w_hex1, w_hex0}, {4{7'b1000000}}); end
    n_cmp++; if ({w_tick, w_done, s_tick, s_done} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pulses got=%b exp=0000", {w_tick, w_done, s_tick, s_done}); end
    rst = 1'b0;
  endtask

  task automatic test_count_up;
    dir = 1'b0; run = 1'b1;
    do_load(16'h0058);
    clk_n(3);
    n_cmp++; if (w_digits !== 16'h0058 || w_tick !== 1'b0) begin
      n_bad++; $display("FAIL up_pre_tick got=%h/%b exp=0058/0", w_digits, w_tick); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0059 || w_tick !== 1'b1 || w_done !== 1'b0) begin
      n_bad++; $display("FAIL up_0059 got=%h/%b/%b exp=0059/1/0", w_digits, w_tick, w_done); end
    clk_n(3);
    n_cmp++; if (w_tick !== 1'b0) begin n_bad++; $display("FAIL up_tick_gap got=%b exp=0", w_tick); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0100 || w_tick !== 1'b1 || w_done !== 1'b0) begin
      n_bad++; $display("FAIL up_0100 got=%h/%b/%b exp=0100/1/0", w_digits, w_tick, w_done); end
  endtask

  task automatic test_async_reset;
    clk_n(1);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (w_digits !== 16'h0000 || s_digits !== 16'h0000) begin
      n_bad++; $display("FAIL async_rst_digits got=%h/%h exp=0000", w_digits, s_digits); end
    n_cmp++; if (w_hex0 !== 7'b1000000 || w_hex2 !== 7'b1000000) begin
      n_bad++; $display("FAIL async_rst_hex got=%b/%b exp=1000000", w_hex0, w_hex2); end
    load = 1'b1; load_value = 16'h1234;
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0000) begin n_bad++; $display("FAIL rst_beats_load got=%h exp=0000", w_digits); end
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic test_wrap_sat;
    int quiet;
    dir = 1'b0; run = 1'b1;
    do_load(16'h5959);
    clk_n(3);
    n_cmp++; if (w_digits !== 16'h5959 || l_digits !== 16'h1259) begin
      n_bad++; $display("FAIL wrap_preload got=%h/%h exp=5959/1259", w_digits, l_digits); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0000 || w_done !== 1'b1 || w_tick !== 1'b1) begin
      n_bad++; $display("FAIL wrap_to_zero got=%h/%b/%b exp=0000/1/1", w_digits, w_done, w_tick); end
    n_cmp++; if (s_digits !== 16'h5959 || s_done !== 1'b1) begin
      n_bad++; $display("FAIL sat_hold got=%h/%b exp=5959/1", s_digits, s_done); end
    n_cmp++; if (l_digits !== 16'h0000 || l_done !== 1'b1) begin
      n_bad++; $display("FAIL lim12_wrap got=%h/%b exp=0000/1", l_digits, l_done); end
    clk_n(1);
    n_cmp++; if (w_done !== 1'b0 || s_done !== 1'b0) begin
      n_bad++; $display("FAIL done_one_cycle got=%b/%b exp=0/0", w_done, s_done); end
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      clk_n(1);
      if (s_tick || s_done) quiet++;
    end
    n_cmp++; if (quiet !== 0 || s_digits !== 16'h5959) begin
      n_bad++; $display("FAIL sat_stays_stopped pulses=%0d digits=%h exp=0/5959", quiet, s_digits); end
    n_cmp++; if (w_digits !== 16'h0003) begin n_bad++; $display("FAIL wrap_keeps_running got=%h exp=0003", w_digits); end
  endtask

  task automatic test_count_down;
    int quiet;
    dir = 1'b1; run = 1'b1;
    do_load(16'h0001);
    clk_n(3);
    n_cmp++; if (w_digits !== 16'h0001) begin n_bad++; $display("FAIL down_pre got=%h exp=0001", w_digits); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0000 || s_digits !== 16'h0000 || w_done !== 1'b0 || s_done !== 1'b0) begin
      n_bad++; $display("FAIL down_to_zero got=%h/%h done=%b%b exp=0000/0000 done=00", w_digits, s_digits, w_done, s_done); end
    clk_n(4);
    n_cmp++; if (w_digits !== 16'h5959 || w_done !== 1'b1) begin
      n_bad++; $display("FAIL down_wrap got=%h/%b exp=5959/1", w_digits, w_done); end
    n_cmp++; if (s_digits !== 16'h0000 || s_done !== 1'b1) begin
      n_bad++; $display("FAIL down_sat got=%h/%b exp=0000/1", s_digits, s_done); end
    n_cmp++; if (l_digits !== 16'h1259 || l_done !== 1'b1) begin
      n_bad++; $display("FAIL lim12_down_wrap got=%h/%b exp=1259/1", l_digits, l_done); end
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      clk_n(1);
      if (s_tick || s_done) quiet++;
    end
    n_cmp++; if (quiet !== 0 || s_digits !== 16'h0000) begin
      n_bad++; $display("FAIL down_sat_stopped pulses=%0d digits=%h exp=0/0000", quiet, s_digits); end
    n_cmp++; if (w_digits !== 16'h5957) begin n_bad++; $display("FAIL down_borrow got=%h exp=5957", w_digits); end
    dir = 1'b0;
    clk_n(3);
    n_cmp++; if (s_digits !== 16'h0000 || s_tick !== 1'b0) begin
      n_bad++; $display("FAIL dir_restart_early got=%h/%b exp=0000/0", s_digits, s_tick); end
    clk_n(1);
    n_cmp++; if (s_digits !== 16'h0001 || s_tick !== 1'b1) begin
      n_bad++; $display("FAIL dir_restart got=%h/%b exp=0001/1", s_digits, s_tick); end
    n_cmp++; if (w_digits !== 16'h5958) begin n_bad++; $display("FAIL dir_flip_wrap got=%h exp=5958", w_digits); end
  endtask

  task automatic test_load;
    run = 1'b0; dir = 1'b0;
    do_load(16'h7A6C);
    n_cmp++; if (w_digits !== 16'h5959 || s_digits !== 16'h5959) begin
      n_bad++; $display("FAIL sanitise_59 got=%h/%h exp=5959", w_digits, s_digits); end
    n_cmp++; if (l_digits !== 16'h1259) begin n_bad++; $display("FAIL sanitise_12 got=%h exp=1259", l_digits); end
    clk_n(1);
    n_cmp++; if (w_hex3 !== 7'b0010010 || w_hex2 !== 7'b0010000) begin
      n_bad++; $display("FAIL hex_59 got=%b/%b exp=0010010/0010000", w_hex3, w_hex2); end
    n_cmp++; if (l_hex3 !== 7'b1111001 || l_hex2 !== 7'b0100100) begin
      n_bad++; $display("FAIL hex_12 got=%b/%b exp=1111001/0100100", l_hex3, l_hex2); end
    run = 1'b1;
    do_load(16'h0000);
    clk_n(3);
    load = 1'b1; load_value = 16'h0010;
    clk_n(1);
    load = 1'b0;
    n_cmp++; if (w_digits !== 16'h0010 || w_tick !== 1'b0) begin
      n_bad++; $display("FAIL load_on_step got=%h/%b exp=0010/0", w_digits, w_tick); end
    clk_n(3);
    n_cmp++; if (w_digits !== 16'h0010 || w_tick !== 1'b0) begin
      n_bad++; $display("FAIL load_presc_restart got=%h/%b exp=0010/0", w_digits, w_tick); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0011 || w_tick !== 1'b1) begin
      n_bad++; $display("FAIL load_then_step got=%h/%b exp=0011/1", w_digits, w_tick); end
  endtask

  task automatic test_fast_freeze;
    fast = 1'b0; run = 1'b1; dir = 1'b0; freeze = 1'b0;
    do_load(16'h0000);
    clk_n(2);
    fast = 1'b1;
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0001 || w_tick !== 1'b1) begin
      n_bad++; $display("FAIL fast_midcount got=%h/%b exp=0001/1", w_digits, w_tick); end
    clk_n(1);
    n_cmp++; if (w_tick !== 1'b0) begin n_bad++; $display("FAIL fast_gap got=%b exp=0", w_tick); end
    clk_n(1);
    n_cmp++; if (w_digits !== 16'h0002 || w_tick !== 1'b1) begin
      n_bad++; $display("FAIL fast_period2 got=%h/%b exp=0002/1", w_digits, w_tick); end
    clk_n(2);
    n_cmp++; if (w_digits !== 16'h0003) begin n_bad++; $display("FAIL fast_0003 got=%h exp=0003", w_digits); end
    clk_n(1);
    n_cmp++; if (w_hex0 !== 7'b0110000 || w_hex1 !== 7'b1000000) begin
      n_bad++; $display("FAIL latch_follows got=%b/%b exp=0110000/1000000", w_hex0, w_hex1); end
    freeze = 1'b1;
    clk_n(19);
    n_cmp++; if (w_digits !== 16'h0013) begin n_bad++; $display("FAIL freeze_live got=%h exp=0013", w_digits); end
    n_cmp++; if (w_hex0 !== 7'b0110000 || w_hex1 !== 7'b1000000) begin
      n_bad++; $display("FAIL freeze_hold got=%b/%b exp=0110000/1000000", w_hex0, w_hex1); end
    freeze = 1'b0;
    clk_n(1);
    n_cmp++; if (w_hex0 !== 7'b0110000 || w_hex1 !== 7'b1111001) begin
      n_bad++; $display("FAIL unfreeze got=%b/%b exp=0110000/1111001", w_hex0, w_hex1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; run = 1'b0; dir = 1'b0; fast = 1'b0;
    load = 1'b0; freeze = 1'b0; load_value = 16'h0000;
    test_reset;
    test_count_up;
    test_async_reset;
    test_wrap_sat;
    test_count_down;
    test_load;
    test_fast_freeze;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
